// File: rtl/ct_readout_pkg.sv
// Shared types and constants for the ciphertext readout/scrub block.
package ct_readout_pkg;

    localparam int unsigned CT_WORDS         = 4;
    localparam int unsigned WORD_W           = 32;
    localparam int unsigned CT_W             = CT_WORDS * WORD_W;
    localparam int unsigned WSEL_W           = 6;
    localparam int unsigned DEFAULT_BASE_IDX = 5;

    localparam int unsigned STAT_DONE_LSB = 0;
    localparam int unsigned STAT_IDLE_BIT = 4;
    localparam int unsigned STAT_HOLD_BIT = 5;
    localparam int unsigned STAT_TMO_BIT  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SCRUB = 2'd2
    } state_e;

    // Status word layout: {25'b0, timeout_cause, hold, idle, rd_done}.
    function automatic logic [WORD_W-1:0] status_word(
        input state_e              st,
        input logic [CT_WORDS-1:0] done,
        input logic                tmo
    );
        logic [WORD_W-1:0] s;
        s                             = '0;
        s[STAT_DONE_LSB +: CT_WORDS]  = done;
        s[STAT_IDLE_BIT]              = (st == ST_IDLE);
        s[STAT_HOLD_BIT]              = (st == ST_HOLD);
        s[STAT_TMO_BIT]               = tmo;
        return s;
    endfunction

endpackage

// File: rtl/ct_read_mux.sv
// Read-side decode: selects word/status data and reports which word a read consumes.
module ct_read_mux
    import ct_readout_pkg::*;
#(
    parameter int unsigned BASE_IDX = DEFAULT_BASE_IDX
) (
    input  state_e                             state_i,
    input  logic [WSEL_W-1:0]                  wsel_i,
    input  logic [CT_WORDS-1:0]                reglk_ctrl_i,
    input  logic [CT_WORDS-1:0][WORD_W-1:0]    ct_words_i,
    input  logic [CT_WORDS-1:0]                rd_done_i,
    input  logic                               tmo_flag_i,
    output logic [WORD_W-1:0]                  rdata_c_o,
    output logic [CT_WORDS-1:0]                rd_set_c_o
);

    logic [WSEL_W-1:0] off_c;
    logic [1:0]        word_c;

    // Indices below BASE_IDX wrap to large offsets and fall through to the "other" case.
    assign off_c  = WSEL_W'(wsel_i - WSEL_W'(BASE_IDX));
    assign word_c = off_c[1:0];

    always_comb begin
        rdata_c_o  = '0;
        rd_set_c_o = '0;
        if (off_c < WSEL_W'(CT_WORDS)) begin
            if ((state_i == ST_HOLD) && !reglk_ctrl_i[word_c] && !rd_done_i[word_c]) begin
                rdata_c_o          = ct_words_i[word_c];
                rd_set_c_o[word_c] = 1'b1;
            end
        end else if (off_c == WSEL_W'(CT_WORDS)) begin
            rdata_c_o = status_word(state_i, rd_done_i, tmo_flag_i);
        end
    end

endmodule

// File: rtl/ct_readout_scrub.sv
// Read-once ciphertext holding register with scrub-to-zero after full readout.
// Optional forced scrub on HOLD timeout: define CT_READOUT_TIMEOUT_EN.
module ct_readout_scrub
    import ct_readout_pkg::*;
#(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned BASE_IDX       = DEFAULT_BASE_IDX
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ct_valid_i,
    input  logic [CT_W-1:0]   ct_i,
    output logic              ct_ready_o,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [CT_WORDS-1:0] reglk_ctrl_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              scrub_o
);

    state_e                          state_q;
    logic [CT_WORDS-1:0][WORD_W-1:0] ct_q;
    logic [CT_WORDS-1:0]             rd_done_q;
    logic [CT_WORDS-1:0]             rd_done_d;
    logic                            ready_q;
    logic [WORD_W-1:0]               rdata_q;
    logic                            rvalid_q;
    logic                            scrub_q;

    logic                            rd_req_c;
    logic [WORD_W-1:0]               rdata_c;
    logic [CT_WORDS-1:0]             rd_set_c;
    logic                            all_done_c;
    logic                            tmo_hit_c;
    logic                            tmo_flag_c;
    logic                            scrub_enter_c;
    logic                            unused_addr_c;

    assign rd_req_c      = en_i && !we_i;
    assign rd_done_d     = rd_done_q | (rd_req_c ? rd_set_c : '0);
    assign all_done_c    = &rd_done_d;
    assign scrub_enter_c = (state_q == ST_HOLD) && (all_done_c || tmo_hit_c);
    assign unused_addr_c = ^address_i[2:0];

    ct_read_mux #(
        .BASE_IDX (BASE_IDX)
    ) u_mux (
        .state_i      (state_q),
        .wsel_i       (address_i[WSEL_W+2:3]),
        .reglk_ctrl_i (reglk_ctrl_i),
        .ct_words_i   (ct_q),
        .rd_done_i    (rd_done_q),
        .tmo_flag_i   (tmo_flag_c),
        .rdata_c_o    (rdata_c),
        .rd_set_c_o   (rd_set_c)
    );

`ifdef CT_READOUT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_flag_q;

    assign tmo_hit_c  = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign tmo_flag_c = tmo_flag_q;

    // Counter idles at zero outside HOLD so it starts fresh on every capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            if (state_q != ST_HOLD) begin
                tmo_cnt_q <= '0;
            end else if (!tmo_hit_c) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (scrub_enter_c) begin
                tmo_flag_q <= tmo_hit_c && !all_done_c;
            end
        end
    end
`else
    localparam int unsigned unused_tmo_cycles = TIMEOUT_CYCLES;

    assign tmo_hit_c  = 1'b0;
    assign tmo_flag_c = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ct_q      <= '0;
            rd_done_q <= '0;
            ready_q   <= 1'b1;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            scrub_q   <= 1'b0;
        end else begin
            rvalid_q <= rd_req_c;
            rdata_q  <= rd_req_c ? rdata_c : '0;
            scrub_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ct_valid_i) begin
                        ct_q      <= ct_i;
                        rd_done_q <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Data is cleared on SCRUB entry so scrub_o marks already-zeroed registers.
                    if (scrub_enter_c) begin
                        ct_q      <= '0;
                        rd_done_q <= '0;
                        scrub_q   <= 1'b1;
                        state_q   <= ST_SCRUB;
                    end else begin
                        rd_done_q <= rd_done_d;
                    end
                end
                ST_SCRUB: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ct_ready_o = ready_q;
    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;
    assign scrub_o    = scrub_q;

endmodule

// File: tb/tb_ct_readout_scrub.sv
// Self-checking bench for ct_readout_scrub with a read-data scoreboard.
module tb_ct_readout_scrub;

`ifdef CT_READOUT_TIMEOUT_EN
    localparam int unsigned TB_TMO = 8;
`else
    localparam int unsigned TB_TMO = 1024;
`endif

    logic         clk;
    logic         rst_n;
    logic         ct_valid;
    logic [127:0] ct;
    logic         ct_ready;
    logic         en;
    logic         we;
    logic [8:0]   addr;
    logic [3:0]   reglk;
    logic [31:0]  rdata;
    logic         rvalid;
    logic         scrub;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [127:0] CT_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] CT_B = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    ct_readout_scrub #(
        .ADDR_W         (9),
        .TIMEOUT_CYCLES (TB_TMO),
        .BASE_IDX       (5)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ct_valid_i   (ct_valid),
        .ct_i         (ct),
        .ct_ready_o   (ct_ready),
        .en_i         (en),
        .we_i         (we),
        .address_i    (addr),
        .reglk_ctrl_i (reglk),
        .rdata_o      (rdata),
        .rvalid_o     (rvalid),
        .scrub_o      (scrub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input logic [127:0] c, input int k);
        return c[32*k +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one read of word-select index sel and queue its expected data.
    task automatic bus_read(input int sel, input logic [31:0] expv);
        en   = 1'b1;
        we   = 1'b0;
        addr = {6'(sel), 3'b000};
        exp_q.push_back(expv);
        tick();
        en = 1'b0;
    endtask

    task automatic capture(input logic [127:0] c);
        ct_valid = 1'b1;
        ct       = c;
        tick();
        ct_valid = 1'b0;
    endtask

    // Scoreboard: every rvalid pulse consumes one expected word, in order.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rvalid with rdata=%h but no read pending", rdata);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h want %h", rdata, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (ct_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ct_ready); end
        checks++;
        if ({rvalid, scrub} !== 2'b00) begin errors++; $display("FAIL reset_flags: got rvalid=%b scrub=%b want 0 0", rvalid, scrub); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        bus_read(9, 32'h10);
    endtask

    task automatic test_basic();
        capture(CT_A);
        checks++;
        if (ct_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_hold: got %b want 0", ct_ready); end
        for (int k = 0; k < 4; k++) bus_read(5 + k, wd(CT_A, k));
        checks++;
        if ({scrub, ct_ready} !== 2'b10) begin errors++; $display("FAIL basic_scrub: got scrub=%b ready=%b want 1 0", scrub, ct_ready); end
        bus_read(5, 32'h0);
        checks++;
        if ({scrub, ct_ready} !== 2'b01) begin errors++; $display("FAIL basic_idle: got scrub=%b ready=%b want 0 1", scrub, ct_ready); end
        bus_read(9, 32'h10);
    endtask

    task automatic test_capture_read();
        ct_valid = 1'b1;
        ct       = CT_A;
        en       = 1'b1;
        we       = 1'b0;
        addr     = {6'd5, 3'b000};
        exp_q.push_back(32'h0);
        tick();
        ct_valid = 1'b0;
        en       = 1'b0;
        bus_read(5, wd(CT_A, 0));
        bus_read(0, 32'h0);
        en   = 1'b1;
        we   = 1'b1;
        addr = {6'd6, 3'b000};
        tick();
        en = 1'b0;
        we = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL write_rvalid: got %b want 0", rvalid); end
        for (int k = 1; k < 4; k++) bus_read(5 + k, wd(CT_A, k));
        tick();
    endtask

    task automatic test_lock();
        capture(CT_A);
        reglk = 4'b0100;
        bus_read(7, 32'h0);
        bus_read(9, 32'h20);
        reglk = 4'b0000;
        bus_read(7, wd(CT_A, 2));
        bus_read(9, 32'h24);
        bus_read(5, wd(CT_A, 0));
        bus_read(6, wd(CT_A, 1));
        bus_read(8, wd(CT_A, 3));
        checks++;
        if (scrub !== 1'b1) begin errors++; $display("FAIL lock_scrub: got %b want 1", scrub); end
        tick();
    endtask

    task automatic test_double_read();
        capture(CT_A);
        bus_read(6, wd(CT_A, 1));
        bus_read(6, 32'h0);
        bus_read(9, 32'h22);
        bus_read(5, wd(CT_A, 0));
        bus_read(7, wd(CT_A, 2));
        bus_read(8, wd(CT_A, 3));
        tick();
    endtask

    task automatic test_hold_ignore();
        capture(CT_A);
        ct_valid = 1'b1;
        ct       = CT_B;
        for (int k = 0; k < 4; k++) bus_read(5 + k, wd(CT_A, k));
        checks++;
        if ({scrub, ct_ready} !== 2'b10) begin errors++; $display("FAIL ignore_scrub: got scrub=%b ready=%b want 1 0", scrub, ct_ready); end
        tick();
        checks++;
        if (ct_ready !== 1'b1) begin errors++; $display("FAIL ignore_idle_ready: got %b want 1", ct_ready); end
        tick();
        ct_valid = 1'b0;
        checks++;
        if (ct_ready !== 1'b0) begin errors++; $display("FAIL ignore_recapture: got %b want 0", ct_ready); end
        for (int k = 0; k < 4; k++) bus_read(5 + k, wd(CT_B, k));
        tick();
    endtask

    task automatic test_reset_mid_hold();
        capture(CT_A);
        bus_read(5, wd(CT_A, 0));
        bus_read(6, wd(CT_A, 1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({scrub, ct_ready, rvalid} !== 3'b010) begin
            errors++;
            $display("FAIL rst_hold_flags: got scrub=%b ready=%b rvalid=%b want 0 1 0", scrub, ct_ready, rvalid);
        end
        for (int k = 0; k < 4; k++) bus_read(5 + k, 32'h0);
        bus_read(9, 32'h10);
        checks++;
        if (scrub !== 1'b0) begin errors++; $display("FAIL rst_hold_noscrub: got %b want 0", scrub); end
    endtask

`ifdef CT_READOUT_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        capture(CT_A);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (scrub === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 9) begin errors++; $display("FAIL tmo_latency: got %0d cycles want 9", n); end
        tick();
        bus_read(9, 32'h50);
        bus_read(5, 32'h0);
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        ct_valid = 1'b0;
        ct       = '0;
        en       = 1'b0;
        we       = 1'b0;
        addr     = '0;
        reglk    = 4'b0000;
        test_reset();
        test_basic();
        test_capture_read();
        test_lock();
        test_double_read();
        test_hold_ignore();
        test_reset_mid_hold();
`ifdef CT_READOUT_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_missing: %0d reads got no rvalid, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
